pipe_stage_buf: RTL

- Generic, parametrised inter-stage pipeline register for the 32-bit pipelined core; replaces fixed per-stage buffers (D/E, E/M, M/W).
- Carries a data bundle and a control bundle with valid/ready handshake, optional 2-entry skid buffering, synchronous flush that inserts bubbles, and a stall-cycle counter.
- Control fields of empty or flushed entries are forced to a parametrised "no-op" value, so downstream write enables never fire on bubbles.

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/pipe_stage_entry.sv | 37 +++
 rtl/pipe_stage_buf.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared bundle layouts for the inter-stage pipeline registers.
// Field widths and the control "no-op" pattern used on bubbles.
package pipe_pkg;

   localparam int DBITS   = 32;
   localparam int REGBITS = 4;
   localparam int OPBITS  = 4;
   localparam int ALUOP_W = 5;

   typedef struct packed {
      logic [DBITS-1:0]   pc;
      logic [DBITS-1:0]   rs1_val;
      logic [DBITS-1:0]   rs2_val;
      logic [DBITS-1:0]   imm;
      logic [REGBITS-1:0] rs1;
      logic [REGBITS-1:0] rs2;
      logic [REGBITS-1:0] rd;
      logic [OPBITS-1:0]  opcode;
   } stage_data_t;

   typedef struct packed {
      logic [ALUOP_W-1:0] alu_op;
      logic [1:0]         a_sel;
      logic [1:0]         b_sel;
      logic               reg_wen;
      logic               mem_wen;
      logic               noop;
      logic [1:0]         pc_sel;
   } stage_ctrl_t;

   localparam int DATA_W_C = $bits(stage_data_t);
   localparam int CTRL_W_C = $bits(stage_ctrl_t);

   localparam stage_ctrl_t CTRL_NOP_C = '0;

endpackage

// File: rtl/pipe_stage_entry.sv
// One pipeline slot: valid flag plus data and control bundles.
// Clearing drops valid and parks control at the no-op pattern.
module pipe_stage_entry
   import pipe_pkg::*;
#(
   parameter int                DATA_W   = DATA_W_C,
   parameter int                CTRL_W   = CTRL_W_C,
   parameter logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{1'b0}}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] ld_data,
   input  logic [CTRL_W-1:0] ld_ctrl,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [CTRL_W-1:0] ctrl
);

   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
         ctrl  <= CTRL_NOP;
      end else if (clear) begin
         // data is left alone; only control must be safe on a bubble
         valid <= 1'b0;
         ctrl  <= CTRL_NOP;
      end else if (load) begin
         valid <= 1'b1;
         data  <= ld_data;
         ctrl  <= ld_ctrl;
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic inter-stage register with valid/ready, optional skid slot,
// flush-to-bubble and a saturating stall counter.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int                DATA_W   = 32*4+4*3+4,
   parameter int                CTRL_W   = 5+2+2+1+1+1+2,
   parameter logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{1'b0}},
   parameter bit                SKID     = 1'b1,
   parameter int                STALL_W  = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [CTRL_W-1:0]  in_ctrl,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic [CTRL_W-1:0]  out_ctrl,
   output logic [STALL_W-1:0] stall_cnt
);

   logic              head_v;
   logic [DATA_W-1:0] head_d;
   logic [CTRL_W-1:0] head_c;
   logic              skid_v;
   logic [DATA_W-1:0] skid_d;
   logic [CTRL_W-1:0] skid_c;

   logic              head_ld;
   logic              head_clr;
   logic              skid_ld;
   logic              skid_clr;
   logic [DATA_W-1:0] head_ld_d;
   logic [CTRL_W-1:0] head_ld_c;

   logic accept;
   logic pop;

   assign accept = in_valid & in_ready;
   assign pop    = head_v & out_ready;

   // skid entry always feeds the head first so order is kept
   assign head_ld_d = skid_v ? skid_d : in_data;
   assign head_ld_c = skid_v ? skid_c : in_ctrl;

   always_comb begin
      head_ld  = 1'b0;
      head_clr = 1'b0;
      skid_ld  = 1'b0;
      skid_clr = 1'b0;
      if (flush) begin
         head_clr = 1'b1;
         skid_clr = 1'b1;
      end else begin
         if (!head_v || pop) begin
            if (skid_v || accept) head_ld = 1'b1;
            else if (head_v)      head_clr = 1'b1;
         end
         if (skid_v) skid_clr = pop;
         else        skid_ld  = accept & head_v & ~pop;
      end
   end

   pipe_stage_entry #(
      .DATA_W   (DATA_W),
      .CTRL_W   (CTRL_W),
      .CTRL_NOP (CTRL_NOP)
   ) u_head (
      .clk     (clk),
      .reset   (reset),
      .load    (head_ld),
      .clear   (head_clr),
      .ld_data (head_ld_d),
      .ld_ctrl (head_ld_c),
      .valid   (head_v),
      .data    (head_d),
      .ctrl    (head_c)
   );

   generate
      if (SKID) begin : g_skid
         pipe_stage_entry #(
            .DATA_W   (DATA_W),
            .CTRL_W   (CTRL_W),
            .CTRL_NOP (CTRL_NOP)
         ) u_skid (
            .clk     (clk),
            .reset   (reset),
            .load    (skid_ld),
            .clear   (skid_clr),
            .ld_data (in_data),
            .ld_ctrl (in_ctrl),
            .valid   (skid_v),
            .data    (skid_d),
            .ctrl    (skid_c)
         );
         // full only when the skid slot holds a beat; purely registered
         assign in_ready = ~skid_v;
      end else begin : g_noskid
         assign skid_v   = 1'b0;
         assign skid_d   = '0;
         assign skid_c   = CTRL_NOP;
         assign in_ready = ~head_v | out_ready;
      end
   endgenerate

   assign out_valid = head_v;
   assign out_data  = head_d;
   assign out_ctrl  = head_c;

   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt <= '0;
      else if (head_v && !out_ready && stall_cnt != {STALL_W{1'b1}})
         stall_cnt <= stall_cnt + 1'b1;
   end

endmodule
